trit_serial_adder: RTL and testbench

- Sequential W-trit balanced-ternary adder/subtractor.
- Processes one trit position per cycle through a single `btfa` instance, least-significant trit first.
- Registers the carry between cycles.
- Sits between the operand source and the result consumer of the ternary datapath, with valid/ready handshakes on both sides.
- Trades latency for area against a ripple array of W `btfa` cells.

---
 rtl/trit_serial_adder.sv | 169 ++++++++++++++++
 tb/tb_trit_serial_adder.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trit_serial_adder.sv
// Sequential balanced-ternary adder/subtractor: one trit position per cycle through a
// single btfa cell, LS trit first, with the carry held in a register between cycles.

module btfa (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] cin,
    output logic [1:0] s,
    output logic [1:0] cout
);
    localparam logic [1:0] T_ZERO    = 2'b00;
    localparam logic [1:0] T_POS_ONE = 2'b01;
    localparam logic [1:0] T_NEG_ONE = 2'b10;

    // Invalid encodings contribute zero to the arithmetic.
    function automatic logic signed [3:0] trit_val(input logic [1:0] t);
        case (t)
            T_POS_ONE: trit_val = 4'sd1;
            T_NEG_ONE: trit_val = -4'sd1;
            default:   trit_val = 4'sd0;
        endcase
    endfunction

    logic signed [3:0] total;

    always_comb begin
        total = trit_val(a) + trit_val(b) + trit_val(cin);
        s     = T_ZERO;
        cout  = T_ZERO;
        case (total)
            -4'sd3: begin s = T_ZERO;    cout = T_NEG_ONE; end
            -4'sd2: begin s = T_POS_ONE; cout = T_NEG_ONE; end
            -4'sd1: begin s = T_NEG_ONE; cout = T_ZERO;    end
            4'sd1:  begin s = T_POS_ONE; cout = T_ZERO;    end
            4'sd2:  begin s = T_NEG_ONE; cout = T_POS_ONE; end
            4'sd3:  begin s = T_ZERO;    cout = T_POS_ONE; end
            default: begin s = T_ZERO;   cout = T_ZERO;    end
        endcase
    end
endmodule

// Handshakes: an input transfer happens on a rising edge where in_valid & in_ready,
// an output transfer where out_valid & out_ready; neither valid is withdrawn by the block.
module trit_serial_adder #(
    parameter int WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    input  logic [1:0]         cin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] sum,
    output logic [1:0]         cout,
    output logic               err,
    output logic [1:0]         dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] T_ZERO    = 2'b00;
    localparam logic [1:0] T_POS_ONE = 2'b01;
    localparam logic [1:0] T_NEG_ONE = 2'b10;
    localparam logic [1:0] T_INVALID = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] a_sr;
    logic [2*WIDTH-1:0] b_sr;
    logic [2*WIDTH-1:0] res_sr;
    logic [1:0]         carry;
    logic [CW-1:0]      cnt;
    logic               err_pend;

    logic [2*WIDTH-1:0] b_load;
    logic               err_in;
    logic [1:0]         fa_s;
    logic [1:0]         fa_cout;
    logic [2*WIDTH-1:0] res_next;
    logic               last_trit;

    // Negating an invalid trit yields zero, so it stays zero in the arithmetic.
    function automatic logic [1:0] neg_trit(input logic [1:0] t);
        case (t)
            T_POS_ONE: neg_trit = T_NEG_ONE;
            T_NEG_ONE: neg_trit = T_POS_ONE;
            default:   neg_trit = T_ZERO;
        endcase
    endfunction

    always_comb begin
        err_in = (cin == T_INVALID);
        b_load = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (a[2*k +: 2] == T_INVALID || b[2*k +: 2] == T_INVALID) begin
                err_in = 1'b1;
            end
            b_load[2*k +: 2] = sub ? neg_trit(b[2*k +: 2]) : b[2*k +: 2];
        end
    end

    btfa u_btfa (
        .a    (a_sr[1:0]),
        .b    (b_sr[1:0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign res_next  = {fa_s, res_sr[2*WIDTH-1:2]};
    assign last_trit = (cnt == CW'(WIDTH - 1));
    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry    <= T_ZERO;
            cnt      <= '0;
            err_pend <= 1'b0;
            sum      <= '0;
            cout     <= T_ZERO;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr     <= a;
                        b_sr     <= b_load;
                        carry    <= cin;
                        cnt      <= '0;
                        err_pend <= err_in;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr   <= {T_ZERO, a_sr[2*WIDTH-1:2]};
                    b_sr   <= {T_ZERO, b_sr[2*WIDTH-1:2]};
                    res_sr <= res_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    // Outputs update only here, so partial results never appear on sum.
                    if (last_trit) begin
                        sum   <= res_next;
                        cout  <= fa_cout;
                        err   <= err_pend;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trit_serial_adder.sv
// Bench for trit_serial_adder: directed cases plus a randomized scoreboard against an
// integer model of balanced-ternary addition.

module tb_trit_serial_adder;
    localparam int W  = 9;
    localparam int RW = 2*W + 3;

    localparam logic [1:0] T_ZERO    = 2'b00;
    localparam logic [1:0] T_POS_ONE = 2'b01;
    localparam logic [1:0] T_NEG_ONE = 2'b10;
    localparam logic [1:0] T_INVALID = 2'b11;

    typedef logic [2*W-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    vec_t       a;
    vec_t       b;
    logic [1:0] cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    vec_t       sum;
    logic [1:0] cout;
    logic       err;
    logic [1:0] dbg_state;

    int tests = 0;
    int fails = 0;
    logic [RW-1:0] exp_q[$];

    trit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int tval(input logic [1:0] t);
        if (t == T_POS_ONE) return 1;
        if (t == T_NEG_ONE) return -1;
        return 0;
    endfunction

    function automatic logic [1:0] to_trit(input int d);
        if (d > 0) return T_POS_ONE;
        if (d < 0) return T_NEG_ONE;
        return T_ZERO;
    endfunction

    function automatic int vval(input vec_t v);
        int acc = 0;
        for (int k = W - 1; k >= 0; k--) acc = acc * 3 + tval(v[2*k +: 2]);
        return acc;
    endfunction

    function automatic vec_t enc(input int x);
        vec_t v = '0;
        int   r;
        for (int k = 0; k < W; k++) begin
            r = x % 3;
            if (r > 1) r -= 3;
            if (r < -1) r += 3;
            v[2*k +: 2] = to_trit(r);
            x = (x - r) / 3;
        end
        return v;
    endfunction

    function automatic logic [RW-1:0] model(input vec_t ma, input vec_t mb,
                                            input logic [1:0] mc, input logic ms);
        int   total;
        int   r;
        logic e;
        vec_t s;
        total = vval(ma) + (ms ? -vval(mb) : vval(mb)) + tval(mc);
        e = (mc == T_INVALID);
        for (int k = 0; k < W; k++) begin
            if (ma[2*k +: 2] == T_INVALID || mb[2*k +: 2] == T_INVALID) e = 1'b1;
            r = total % 3;
            if (r > 1) r -= 3;
            if (r < -1) r += 3;
            s[2*k +: 2] = to_trit(r);
            total = (total - r) / 3;
        end
        return {e, to_trit(total), s};
    endfunction

    function automatic logic [1:0] rand_trit();
        int r = $urandom_range(0, 2);
        return (r == 0) ? T_ZERO : (r == 1) ? T_POS_ONE : T_NEG_ONE;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < W; k++) v[2*k +: 2] = rand_trit();
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t ta, input vec_t tb2, input logic [1:0] tc, input logic ts);
        int n = 0;
        a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        a = vec_t'($urandom); b = vec_t'($urandom); cin = 2'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 4*W + 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input vec_t ta, input vec_t tb2, input logic [1:0] tc, input logic ts,
                         output logic [RW-1:0] got, output int lat);
        send(ta, tb2, tc, ts);
        wait_out(lat);
        got = {err, cout, sum};
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = T_ZERO; sub = 1'b0;
        tick(); tick();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_handshake in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
        end
        tests++;
        if (sum !== '0 || cout !== T_ZERO || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs sum=%h cout=%b err=%b required 0/00/0", sum, cout, err);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release in_ready=%b required=1", in_ready);
        end
    endtask

    task automatic test_basic();
        int ca[6] = '{5, 9841, -9841, 5, 0, 13};
        int cb[6] = '{7, 9841, -9841, 7, -9841, -4};
        int cc[6] = '{0, 1, -1, 0, 0, 1};
        int cs[6] = '{0, 0, 0, 1, 1, 1};
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        int lat;
        int want;
        int have;
        for (int i = 0; i < 6; i++) begin
            exp = model(enc(ca[i]), enc(cb[i]), to_trit(cc[i]), cs[i] != 0);
            do_op(enc(ca[i]), enc(cb[i]), to_trit(cc[i]), cs[i] != 0, got, lat);
            tests++;
            if (lat !== W) begin
                fails++;
                $display("FAIL basic_latency case=%0d got=%0d required=%0d", i, lat, W);
            end
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL basic_result case=%0d got=%h required=%h", i, got, exp);
            end
            want = ca[i] + (cs[i] != 0 ? -cb[i] : cb[i]) + cc[i];
            have = vval(got[2*W-1:0]) + 19683 * tval(got[2*W+1:2*W]);
            tests++;
            if (have !== want) begin
                fails++;
                $display("FAIL basic_value case=%0d got=%0d required=%0d", i, have, want);
            end
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL basic_after_hs case=%0d out_valid=%b in_ready=%b required 0/1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_invalid();
        vec_t av;
        vec_t bv;
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        int lat;
        av = enc(3);
        av[9:8] = T_INVALID;
        do_op(av, enc(1), T_ZERO, 1'b0, got, lat);
        exp = {1'b1, T_ZERO, enc(4)};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL invalid_a got=%h required=%h", got, exp);
        end
        do_op(enc(2), enc(2), T_ZERO, 1'b0, got, lat);
        exp = {1'b0, T_ZERO, enc(4)};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL invalid_clean_next got=%h required=%h", got, exp);
        end
        bv = enc(-5);
        bv[1:0] = T_INVALID;
        exp = model(enc(3), bv, T_INVALID, 1'b1);
        do_op(enc(3), bv, T_INVALID, 1'b1, got, lat);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL invalid_sub_cin got=%h required=%h", got, exp);
        end
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] exp;
        logic [RW-1:0] snap;
        int lat;
        exp = model(enc(100), enc(-37), T_POS_ONE, 1'b0);
        send(enc(100), enc(-37), T_POS_ONE, 1'b0);
        wait_out(lat);
        snap = {err, cout, sum};
        tests++;
        if (snap !== exp) begin
            fails++;
            $display("FAIL bp_result got=%h required=%h", snap, exp);
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            a = rand_vec(); b = rand_vec(); cin = rand_trit();
            tick();
            tests++;
            if ({err, cout, sum} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_stall cycle=%0d out=%h ov=%b ir=%b required %h/1/0",
                         i, {err, cout, sum}, out_valid, in_ready, exp);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_no_spurious_accept out_valid=%b in_ready=%b required 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        int lat;
        logic seen;
        send(enc(200), enc(57), T_ZERO, 1'b1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || sum !== '0 || cout !== T_ZERO || err !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_state ov=%b ir=%b sum=%h cout=%b err=%b required 0/0/0/00/0",
                     out_valid, in_ready, sum, cout, err);
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2*W; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_no_output seen_valid=%b in_ready=%b required 0/1", seen, in_ready);
        end
        exp = model(enc(-1234), enc(4321), T_NEG_ONE, 1'b0);
        do_op(enc(-1234), enc(4321), T_NEG_ONE, 1'b0, got, lat);
        tests++;
        if (got !== exp || lat !== W) begin
            fails++;
            $display("FAIL rst_mid_next_op got=%h lat=%0d required=%h lat=%0d", got, lat, exp, W);
        end
    endtask

    task automatic test_random();
        vec_t ta;
        vec_t tb2;
        logic [1:0] tc;
        logic ts;
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        logic r;
        logic done;
        int k;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            ta = rand_vec(); tb2 = rand_vec(); tc = rand_trit(); ts = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) ta[2*$urandom_range(0, W-1) +: 2] = T_INVALID;
                else tb2[2*$urandom_range(0, W-1) +: 2] = T_INVALID;
            end
            exp_q.push_back(model(ta, tb2, tc, ts));
            send(ta, tb2, tc, ts);
            done = 1'b0;
            k = 0;
            while (!done && k < 200) begin
                r = 1'($urandom);
                out_ready = r;
                if (out_valid && r) begin
                    got = {err, cout, sum};
                    done = 1'b1;
                end
                tick();
                k++;
            end
            out_ready = 1'b0;
            tests++;
            if (!done) begin
                fails++;
                $display("FAIL rand_timeout op=%0d out_valid=%b required=1", n, out_valid);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL rand_result op=%0d got=%h required=%h", n, got, exp);
                end
            end
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL rand_duplicate op=%0d out_valid=%b required=0", n, out_valid);
            end
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rand_queue_left size=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
